player_action_sequencer: RTL and testbench
==========================================

// Module: player_action_sequencer
// PURPOSE
//   Front-end controller for one player action. Collects the per-action input beats from the
//   Data bus (usertype::Data), fetches the player's Player_Info record over a DRAM read channel,
//   and issues one command to the action datapath. It writes the updated record back when
//   required, then returns warn_msg and complete.
//   Only one action is in flight at a time; the block is the only DRAM master for player records.
// PARAMETERS
//   ADDR_W     17        DRAM byte-address width
//   DATA_W     96        DRAM data width; Player_Info occupies [88:0], [95:89] written 0
//   BASE_ADDR  17'h10000 address of player 0 record; stride 16 bytes
// PORTS
//   clk              in   1    clock, all logic on rising edge
//   rst              in   1    synchronous, active-high reset
//   sel_action_valid in   1    D.d_act[0] carries Action
//   type_valid       in   1    D.d_type[0] carries Training_Type
//   mode_valid       in   1    D.d_mode[0] carries Mode
//   date_valid       in   1    D.d_date[0] carries Date
//   player_no_valid  in   1    D.d_player_no[0] carries Player_No
//   attr_valid       in   1    D.d_attribute[0] carries one Attribute beat
//   D                in   144  Data union
//   ar_valid/ar_addr out  1/ADDR_W  read address; ar_ready in 1
//   r_valid/r_data   in   1/DATA_W  read data;    r_ready out 1
//   wr_valid         out  1    write address+data valid; wr_addr ADDR_W, wr_data DATA_W out
//   wr_ready         in   1    write accepted;  b_valid in 1 write response
//   cmd_valid        out  1    one-cycle command strobe to datapath
//   cmd_act/type/mode/date out 3/2/2/9   latched fields
//   cmd_attr         out  64   attr beats, beat k at [16k+15:16k], unused beats 0
//   cmd_info         out  89   Player_Info read from DRAM
//   dp_done          in   1    datapath result strobe; dp_info 89, dp_warn 3, dp_wb 1 (in)
//   out_valid        out  1    one-cycle result; warn_msg 3 (Warn_Msg), complete 1 (out)
// BEHAVIOUR
//   - Reset: every output 0, all latched fields 0, state IDLE. Reset in any state aborts the
//     action without issuing further DRAM traffic; the next edge after reset deasserts is IDLE.
//   - States: IDLE, COLLECT, RD_ADDR, RD_DATA, EXEC, WAIT_DP, WR_REQ, WR_RESP, DONE.
//   - Beat order is fixed: action, [type, mode], date, player_no, [attr x N].
//     Level_Up takes type+mode. Battle takes N=3 attr beats. Use_Skill takes N=4.
//     Login and Check_Inactive take neither.
//   - IDLE accepts only sel_action_valid and then moves to COLLECT. Any strobe not expected next
//     in the order, and any strobe while busy, is ignored. Surplus attr beats are ignored.
//   - The cycle after the final beat is latched: RD_ADDR, with ar_valid=1 and
//     ar_addr = BASE_ADDR + {player_no,4'b0}. ar_valid and ar_addr stay stable until ar_ready.
//   - RD_DATA: r_ready=1 and r_data[88:0] is latched into cmd_info when r_valid=1.
//     r_valid in the same cycle as the ar handshake is not sampled.
//   - EXEC: cmd_valid=1 for exactly one cycle, then WAIT_DP. dp_done is sampled only in WAIT_DP.
//   - On dp_done, latch dp_warn and dp_info. If dp_wb=1 and dp_warn==No_Warn, go to WR_REQ.
//     Otherwise go to DONE.
//   - WR_REQ: wr_valid=1, wr_addr=read address, wr_data={7'b0,dp_info}. Held until wr_ready.
//     Then WR_RESP waits for b_valid (b_valid in the wr_ready cycle counts).
//   - DONE: out_valid=1 for one cycle, warn_msg=latched dp_warn, complete=(dp_warn==No_Warn).
//     Then IDLE. warn_msg and complete read 0 whenever out_valid=0.
//   - A new sel_action_valid is accepted no earlier than the cycle after out_valid.
// TESTING
//   1. Login, date 3/14, player 5 -> ar_addr=17'h10050; dp_done wb=1 warn=000 -> wr_addr=17'h10050,
//      after b_valid: out_valid=1, warn_msg=000, complete=1.
//   2. Battle, 3 attr beats 16'h0010/0020/0030 -> cmd_attr=64'h0000_0030_0020_0010;
//      dp_warn=011 -> no wr_valid, out_valid with warn_msg=011, complete=0.
//   3. Use_Skill, player 255, ar_ready low 5 cycles -> ar_valid held with ar_addr=17'h10FF0 stable;
//      cmd_valid high exactly 1 cycle.
//   4. date_valid in IDLE, then a 4th attr beat on Battle -> both ignored; cmd_attr[63:48]=0.
//   5. rst during RD_DATA -> next cycle all outputs 0; a following Login completes normally.
//   6. dp_wb=1 with dp_warn=001 -> no write; out_valid warn_msg=001, complete=0.

Source files
------------

// File: rtl/player_action_sequencer.sv
// Sequences one player action: collects input beats, reads the player record, issues the datapath
// command and optionally writes the record back. D fields sit at the LSBs; Action 0..4 = Login, Level_Up, Battle, Use_Skill, Check_Inactive.
module player_action_sequencer #(
  parameter int unsigned       ADDR_W    = 17,
  parameter int unsigned       DATA_W    = 96,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 17'h10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_action_valid,
  input  logic              type_valid,
  input  logic              mode_valid,
  input  logic              date_valid,
  input  logic              player_no_valid,
  input  logic              attr_valid,
  input  logic [143:0]      D,
  output logic              ar_valid,
  output logic [ADDR_W-1:0] ar_addr,
  input  logic              ar_ready,
  input  logic              r_valid,
  input  logic [DATA_W-1:0] r_data,
  output logic              r_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  input  logic              b_valid,
  output logic              cmd_valid,
  output logic [2:0]        cmd_act,
  output logic [1:0]        cmd_type,
  output logic [1:0]        cmd_mode,
  output logic [8:0]        cmd_date,
  output logic [63:0]       cmd_attr,
  output logic [88:0]       cmd_info,
  input  logic              dp_done,
  input  logic [88:0]       dp_info,
  input  logic [2:0]        dp_warn,
  input  logic              dp_wb,
  output logic              out_valid,
  output logic [2:0]        warn_msg,
  output logic              complete
);

  typedef enum logic [3:0] {
    S_IDLE, S_COLLECT, S_RD_ADDR, S_RD_DATA, S_EXEC, S_WAIT_DP, S_WR_REQ, S_WR_RESP, S_DONE
  } state_e;

  typedef enum logic [2:0] {E_TYPE, E_MODE, E_DATE, E_PNO, E_ATTR} beat_e;

  localparam logic [2:0] ACT_LEVEL_UP  = 3'd1;
  localparam logic [2:0] ACT_BATTLE    = 3'd2;
  localparam logic [2:0] ACT_USE_SKILL = 3'd3;

  state_e            state_q, state_d;
  beat_e             exp_q, exp_d;
  logic [2:0]        attr_cnt_q, attr_cnt_d;
  logic [2:0]        act_q, act_d;
  logic [1:0]        type_q, type_d;
  logic [1:0]        mode_q, mode_d;
  logic [8:0]        date_q, date_d;
  logic [7:0]        pno_q, pno_d;
  logic [15:0]       attr_q [4];
  logic [15:0]       attr_d [4];
  logic [88:0]       info_q, info_d;
  logic [88:0]       wb_info_q, wb_info_d;
  logic [2:0]        warn_q, warn_d;
  logic [2:0]        n_attr;
  logic [ADDR_W-1:0] rec_addr;
  logic              unused_ok;

  assign unused_ok = ^{D[143:16], r_data[DATA_W-1:89]};
  assign n_attr    = (act_q == ACT_BATTLE) ? 3'd3 : (act_q == ACT_USE_SKILL) ? 3'd4 : 3'd0;
  assign rec_addr  = BASE_ADDR + ADDR_W'({pno_q, 4'b0000});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      exp_q      <= E_DATE;
      attr_cnt_q <= '0;
      act_q      <= '0;
      type_q     <= '0;
      mode_q     <= '0;
      date_q     <= '0;
      pno_q      <= '0;
      attr_q     <= '{default: '0};
      info_q     <= '0;
      wb_info_q  <= '0;
      warn_q     <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      attr_cnt_q <= attr_cnt_d;
      act_q      <= act_d;
      type_q     <= type_d;
      mode_q     <= mode_d;
      date_q     <= date_d;
      pno_q      <= pno_d;
      attr_q     <= attr_d;
      info_q     <= info_d;
      wb_info_q  <= wb_info_d;
      warn_q     <= warn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    attr_cnt_d = attr_cnt_q;
    act_d      = act_q;
    type_d     = type_q;
    mode_d     = mode_q;
    date_d     = date_q;
    pno_d      = pno_q;
    attr_d     = attr_q;
    info_d     = info_q;
    wb_info_d  = wb_info_q;
    warn_d     = warn_q;
    unique case (state_q)
      S_IDLE: begin
        // A new action clears every field so unused beats read back as zero.
        if (sel_action_valid) begin
          act_d      = D[2:0];
          type_d     = '0;
          mode_d     = '0;
          date_d     = '0;
          pno_d      = '0;
          attr_d     = '{default: '0};
          attr_cnt_d = '0;
          exp_d      = (D[2:0] == ACT_LEVEL_UP) ? E_TYPE : E_DATE;
          state_d    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        unique case (exp_q)
          E_TYPE: if (type_valid) begin
            type_d = D[1:0];
            exp_d  = E_MODE;
          end
          E_MODE: if (mode_valid) begin
            mode_d = D[1:0];
            exp_d  = E_DATE;
          end
          E_DATE: if (date_valid) begin
            date_d = D[8:0];
            exp_d  = E_PNO;
          end
          E_PNO: if (player_no_valid) begin
            pno_d = D[7:0];
            if (n_attr == 3'd0) state_d = S_RD_ADDR;
            else                exp_d   = E_ATTR;
          end
          E_ATTR: if (attr_valid) begin
            attr_d[attr_cnt_q[1:0]] = D[15:0];
            attr_cnt_d              = attr_cnt_q + 3'd1;
            if (attr_cnt_q + 3'd1 == n_attr) state_d = S_RD_ADDR;
          end
          default: ;
        endcase
      end
      S_RD_ADDR: if (ar_ready) state_d = S_RD_DATA;
      S_RD_DATA: if (r_valid) begin
        info_d  = r_data[88:0];
        state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WAIT_DP;
      S_WAIT_DP: if (dp_done) begin
        warn_d    = dp_warn;
        wb_info_d = dp_info;
        state_d   = (dp_wb && dp_warn == 3'd0) ? S_WR_REQ : S_DONE;
      end
      // A response arriving with the write acceptance skips the response wait.
      S_WR_REQ:  if (wr_ready) state_d = b_valid ? S_DONE : S_WR_RESP;
      S_WR_RESP: if (b_valid) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ar_valid  = 1'b0;
    ar_addr   = '0;
    r_ready   = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    cmd_valid = 1'b0;
    out_valid = 1'b0;
    warn_msg  = '0;
    complete  = 1'b0;
    unique case (state_q)
      S_RD_ADDR: begin
        ar_valid = 1'b1;
        ar_addr  = rec_addr;
      end
      S_RD_DATA: r_ready = 1'b1;
      S_EXEC:    cmd_valid = 1'b1;
      S_WR_REQ: begin
        wr_valid = 1'b1;
        wr_addr  = rec_addr;
        wr_data  = DATA_W'(wb_info_q);
      end
      S_DONE: begin
        out_valid = 1'b1;
        warn_msg  = warn_q;
        complete  = (warn_q == 3'd0);
      end
      default: ;
    endcase
  end

  assign cmd_act  = act_q;
  assign cmd_type = type_q;
  assign cmd_mode = mode_q;
  assign cmd_date = date_q;
  assign cmd_info = info_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_attr
    assign cmd_attr[16*gi +: 16] = attr_q[gi];
  end

endmodule

// File: tb/tb_player_action_sequencer.sv
// Directed and randomized action sequences against a reference model of the beat order,
// record addressing, command contents and write-back decision.
module tb_player_action_sequencer;
    localparam logic [2:0] LOGIN = 3'd0, LEVEL_UP = 3'd1, BATTLE = 3'd2, USE_SKILL = 3'd3, CHECK_INACTIVE = 3'd4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel_action_valid, type_valid, mode_valid, date_valid, player_no_valid, attr_valid;
    logic [143:0] D;
    logic         ar_valid, ar_ready, r_valid, r_ready;
    logic [16:0]  ar_addr, wr_addr;
    logic [95:0]  r_data, wr_data;
    logic         wr_valid, wr_ready, b_valid;
    logic         cmd_valid;
    logic [2:0]   cmd_act;
    logic [1:0]   cmd_type, cmd_mode;
    logic [8:0]   cmd_date;
    logic [63:0]  cmd_attr;
    logic [88:0]  cmd_info;
    logic         dp_done, dp_wb;
    logic [88:0]  dp_info;
    logic [2:0]   dp_warn;
    logic         out_valid, complete;
    logic [2:0]   warn_msg;
    logic [307:0] all_out;
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_act = 0;
    bit           finished = 1'b0;

    always #5 clk = ~clk;

    player_action_sequencer dut (
        .clk(clk), .rst(rst),
        .sel_action_valid(sel_action_valid), .type_valid(type_valid), .mode_valid(mode_valid),
        .date_valid(date_valid), .player_no_valid(player_no_valid), .attr_valid(attr_valid), .D(D),
        .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .b_valid(b_valid),
        .cmd_valid(cmd_valid), .cmd_act(cmd_act), .cmd_type(cmd_type), .cmd_mode(cmd_mode),
        .cmd_date(cmd_date), .cmd_attr(cmd_attr), .cmd_info(cmd_info),
        .dp_done(dp_done), .dp_info(dp_info), .dp_warn(dp_warn), .dp_wb(dp_wb),
        .out_valid(out_valid), .warn_msg(warn_msg), .complete(complete)
    );

    assign all_out = {ar_valid, ar_addr, r_ready, wr_valid, wr_addr, wr_data, cmd_valid, cmd_act,
                      cmd_type, cmd_mode, cmd_date, cmd_attr, cmd_info, out_valid, warn_msg, complete};

    task automatic chk(input string tag, input logic [307:0] obs, input logic [307:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int n_attr_of(input logic [2:0] a);
        return (a == BATTLE) ? 3 : (a == USE_SKILL) ? 4 : 0;
    endfunction

    function automatic logic [16:0] addr_of(input logic [7:0] p);
        return 17'h10000 + 17'(p) * 17'd16;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 action, 1 type, 2 mode, 3 date, 4 player_no, 5 attr; upper D bits are noise
    task automatic drive_beat(input int kind, input logic [15:0] val);
        logic [143:0] d;
        d = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
        case (kind)
            0: begin d[2:0] = val[2:0];  sel_action_valid = 1'b1; end
            1: begin d[1:0] = val[1:0];  type_valid       = 1'b1; end
            2: begin d[1:0] = val[1:0];  mode_valid       = 1'b1; end
            3: begin d[8:0] = val[8:0];  date_valid       = 1'b1; end
            4: begin d[7:0] = val[7:0];  player_no_valid  = 1'b1; end
            default: begin d[15:0] = val; attr_valid = 1'b1; end
        endcase
        D = d;
        tick();
        {sel_action_valid, type_valid, mode_valid, date_valid, player_no_valid, attr_valid} = '0;
    endtask

    task automatic send_beats(input logic [2:0] act, input logic [1:0] ty, input logic [1:0] md,
                              input logic [8:0] dt, input logic [7:0] pno, input logic [63:0] attrs,
                              input int nsend, input bit junk);
        int          kinds[$];
        logic [15:0] vals[$];
        kinds.push_back(0); vals.push_back({13'b0, act});
        if (act == LEVEL_UP) begin
            kinds.push_back(1); vals.push_back({14'b0, ty});
            kinds.push_back(2); vals.push_back({14'b0, md});
        end
        kinds.push_back(3); vals.push_back({7'b0, dt});
        kinds.push_back(4); vals.push_back({8'b0, pno});
        for (int k = 0; k < nsend; k++) begin
            kinds.push_back(5); vals.push_back(attrs[16*k +: 16]);
        end
        foreach (kinds[i]) begin
            // Out-of-order strobe of a kind other than the one due next must be ignored.
            if (junk && $urandom_range(1, 0) == 1)
                drive_beat((kinds[i] + int'($urandom_range(5, 1))) % 6, 16'($urandom));
            drive_beat(kinds[i], vals[i]);
        end
    endtask

    task automatic run_action(input logic [2:0] act, input logic [1:0] ty, input logic [1:0] md,
                              input logic [8:0] dt, input logic [7:0] pno, input logic [63:0] attrs,
                              input int ar_dly, input int r_dly, input int dp_dly,
                              input logic [2:0] warn, input logic wb, input int wr_dly, input int b_dly,
                              input bit surplus, input bit junk);
        int          n;
        logic [63:0] exp_attr;
        logic [16:0] ea;
        logic [95:0] rd;
        logic [88:0] info;
        bit          do_wr;
        n = n_attr_of(act);
        exp_attr = '0;
        for (int k = 0; k < n; k++) exp_attr[16*k +: 16] = attrs[16*k +: 16];
        ea    = addr_of(pno);
        do_wr = wb && (warn == 3'd0);

        send_beats(act, ty, md, dt, pno, attrs, n, junk);
        chk("ar_valid", ar_valid, 1'b1);
        chk("ar_addr", ar_addr, ea);
        for (int i = 0; i < ar_dly; i++) begin
            if (i == 0 && surplus) begin
                attr_valid = 1'b1;
                D = {128'b0, 16'hbeef};
            end
            tick();
            attr_valid = 1'b0;
            chk("ar_hold_valid", ar_valid, 1'b1);
            chk("ar_hold_addr", ar_addr, ea);
        end
        ar_ready = 1'b1;
        r_valid  = 1'b1;
        r_data   = {$urandom, $urandom, $urandom};
        tick();
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        chk("r_ready", r_ready, 1'b1);
        chk("ar_drop", ar_valid, 1'b0);
        for (int i = 0; i < r_dly; i++) begin
            tick();
            chk("r_wait_cmd", cmd_valid, 1'b0);
        end
        rd      = {$urandom, $urandom, $urandom};
        r_valid = 1'b1;
        r_data  = rd;
        tick();
        r_valid = 1'b0;
        r_data  = {$urandom, $urandom, $urandom};
        chk("cmd_valid", cmd_valid, 1'b1);
        chk("cmd_info", cmd_info, rd[88:0]);
        chk("cmd_act", cmd_act, act);
        chk("cmd_type", cmd_type, (act == LEVEL_UP) ? ty : 2'b00);
        chk("cmd_mode", cmd_mode, (act == LEVEL_UP) ? md : 2'b00);
        chk("cmd_date", cmd_date, dt);
        chk("cmd_attr", cmd_attr, exp_attr);
        tick();
        chk("cmd_once", cmd_valid, 1'b0);
        for (int i = 0; i < dp_dly; i++) begin
            tick();
            chk("dp_wait_out", out_valid, 1'b0);
        end
        info    = {25'($urandom), $urandom, $urandom};
        dp_done = 1'b1;
        dp_info = info;
        dp_warn = warn;
        dp_wb   = wb;
        tick();
        dp_done = 1'b0;
        dp_info = {25'($urandom), $urandom, $urandom};
        dp_warn = 3'($urandom);
        dp_wb   = 1'($urandom);
        if (do_wr) begin
            chk("wr_valid", wr_valid, 1'b1);
            chk("wr_addr", wr_addr, ea);
            chk("wr_data", wr_data, {7'b0, info});
            for (int i = 0; i < wr_dly; i++) begin
                tick();
                chk("wr_hold", wr_valid, 1'b1);
                chk("wr_hold_data", wr_data, {7'b0, info});
            end
            wr_ready = 1'b1;
            b_valid  = (b_dly == 0);
            tick();
            wr_ready = 1'b0;
            b_valid  = 1'b0;
            chk("wr_drop", wr_valid, 1'b0);
            for (int i = 0; i < b_dly; i++) begin
                chk("b_wait_out", out_valid, 1'b0);
                if (i == b_dly - 1) b_valid = 1'b1;
                tick();
                b_valid = 1'b0;
            end
        end else begin
            chk("no_write", wr_valid, 1'b0);
        end
        chk("out_valid", out_valid, 1'b1);
        chk("warn_msg", warn_msg, warn);
        chk("complete", complete, (warn == 3'd0));
        if (junk) begin
            sel_action_valid = 1'b1;
            D = {141'b0, 3'd1};
        end
        tick();
        sel_action_valid = 1'b0;
        chk("out_drop", out_valid, 1'b0);
        chk("warn_idle", warn_msg, 3'b000);
        chk("complete_idle", complete, 1'b0);
        n_act++;
        $display("action %0d: act=%0d player=%0d addr=%h warn=%0d wb=%0d write=%0d", n_act, act, pno, ea, warn, wb, do_wr);
    endtask

    initial begin
        #2000000;
        chk("watchdog_expired", finished, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        logic [2:0]  r_act;
        logic [2:0]  r_warn;
        int          r_ar;
        bit          r_sur;
        {sel_action_valid, type_valid, mode_valid, date_valid, player_no_valid, attr_valid} = '0;
        D = '0; ar_ready = 0; r_valid = 0; r_data = '0; wr_ready = 0; b_valid = 0;
        dp_done = 0; dp_info = '0; dp_warn = '0; dp_wb = 0;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_outs", all_out, 308'b0);
        rst = 1'b0;

        // Login 3/14 player 5 with write-back
        run_action(LOGIN, 2'd0, 2'd0, {4'd3, 5'd14}, 8'd5, 64'h0, 0, 1, 2, 3'b000, 1'b1, 1, 1, 0, 0);
        // Battle with three attribute beats, warning suppresses the write
        run_action(BATTLE, 2'd0, 2'd0, 9'h021, 8'd17, 64'h0000_0030_0020_0010, 0, 0, 1, 3'b011, 1'b1, 0, 0, 0, 0);
        // Use_Skill player 255 with a slow address handshake
        run_action(USE_SKILL, 2'd0, 2'd0, 9'h1a3, 8'd255, 64'h4444_3333_2222_1111, 5, 2, 0, 3'b000, 1'b0, 0, 0, 0, 0);
        // Stray date strobe in IDLE, then Battle with a surplus fourth attribute beat
        drive_beat(3, 16'h01ff);
        run_action(BATTLE, 2'd0, 2'd0, 9'h045, 8'd3, 64'hdead_0c0c_0b0b_0a0a, 1, 0, 0, 3'b000, 1'b1, 0, 2, 1, 0);
        // Reset while waiting for read data
        send_beats(LOGIN, 2'd0, 2'd0, 9'h07f, 8'd9, 64'h0, 0, 0);
        chk("rst_ar_valid", ar_valid, 1'b1);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        chk("rst_in_rd_data", r_ready, 1'b1);
        rst     = 1'b1;
        r_valid = 1'b1;
        r_data  = {$urandom, $urandom, $urandom};
        tick();
        rst     = 1'b0;
        r_valid = 1'b0;
        chk("rst_mid_outs", all_out, 308'b0);
        tick();
        chk("rst_idle_outs", all_out, 308'b0);
        run_action(LOGIN, 2'd0, 2'd0, {4'd7, 5'd1}, 8'd42, 64'h0, 0, 0, 0, 3'b000, 1'b1, 0, 1, 0, 0);
        // Write-back requested but warning present
        run_action(LEVEL_UP, 2'd2, 2'd1, {4'd12, 5'd31}, 8'd128, 64'h0, 1, 1, 1, 3'b001, 1'b1, 0, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            r_act  = 3'($urandom_range(4, 0));
            r_warn = ($urandom_range(1, 0) == 1) ? 3'b000 : 3'($urandom);
            r_sur  = ($urandom_range(3, 0) == 0);
            r_ar   = $urandom_range(3, 0);
            if (r_sur && r_ar == 0) r_ar = 1;
            run_action(r_act, 2'($urandom), 2'($urandom), 9'($urandom), 8'($urandom),
                       {$urandom, $urandom}, r_ar, $urandom_range(3, 0), $urandom_range(3, 0),
                       r_warn, 1'($urandom), $urandom_range(2, 0), $urandom_range(2, 0), r_sur,
                       ($urandom_range(1, 0) == 1));
        end

        finished = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
